// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle control unit for the kanade32 datapath. A Moore FSM sequences
// fetch, decode, execute, memory and write-back for the supported subset
// (lw, sw, R-type add/sub/and/or/slt, beq, addi, j). It is the initiator side
// of the ALU op interface: it drives the ALU op code and operand selects and
// consumes the ALU zero flag for beq.
//
// Configuration macro:
//   MULTICYCLE_CTRL_MEM_WAIT_EN
//     defined   : FETCH, MEMRD and MEMWR hold until mem_ready=1; strobes stay
//                 asserted while waiting and ir_write/pc_en stay 0.
//     undefined : mem_ready is ignored (treated as 1); each memory state
//                 lasts exactly one cycle.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   opcode     in   6  IR[31:26]
//   funct      in   6  IR[5:0]
//   zero       in   1  ALU zero flag (beq condition)
//   mem_ready  in   1  memory access completes this cycle
//   alu_op     out  3  ALU operation
//   alu_src_a  out  1  0=PC, 1=reg A
//   alu_src_b  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
//   pc_src     out  2  00=ALU result, 01=ALUOut register, 10=jump target
//   pc_en      out  1  PC write enable
//   iord       out  1  memory address select: 0=PC, 1=ALUOut
//   mem_read   out  1  memory read strobe
//   mem_write  out  1  memory write strobe
//   ir_write   out  1  IR load enable
//   reg_write  out  1  register file write enable
//   reg_dst    out  1  0=rt, 1=rd
//   mem_to_reg out  1  0=ALUOut, 1=MDR
//   illegal    out  1  unsupported opcode (DECODE) or funct (EXEC), one cycle
//   state      out  4  current state, for debug
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    // ALU op codes shared with the datapath ALU
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    // Opcodes of the supported instructions
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // State encoding is visible on the debug port, so it is fixed
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_rdy_s;
    logic       funct_legal_s;
    logic [2:0] funct_alu_s;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_rdy_s = mem_ready;
`else
    // Memory is assumed single-cycle: the handshake is forced complete.
    assign mem_rdy_s = mem_ready | 1'b1;
`endif

    assign state = state_q;

    // R-type funct decode: ALU operation and legality
    always_comb begin
        funct_legal_s = 1'b1;
        funct_alu_s   = ALU_OP_ADD;
        case (funct)
            FN_ADD:  funct_alu_s = ALU_OP_ADD;
            FN_SUB:  funct_alu_s = ALU_OP_SUB;
            FN_AND:  funct_alu_s = ALU_OP_AND;
            FN_OR:   funct_alu_s = ALU_OP_OR;
            FN_SLT:  funct_alu_s = ALU_OP_SLT;
            default: begin
                funct_legal_s = 1'b0;
                funct_alu_s   = ALU_OP_ADD;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (mem_rdy_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Only lw/sw reach here, so anything not lw is a store
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_rdy_s) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_rdy_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                // Illegal funct abandons the instruction without write-back
                if (funct_legal_s) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from state; reset masks every side-effecting enable
    always_comb begin
        alu_op     = ALU_OP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is written together with the IR when the fetch completes
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_rdy_s;
                pc_en     = mem_rdy_s;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_s;
                illegal   = ~funct_legal_s;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: begin
                alu_op = ALU_OP_ADD;
            end
        endcase
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            illegal   = 1'b0;
        end else begin
            illegal = illegal;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pc_en;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       ill;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    outv_t dut_v;
    outv_t exp_v;
    assign dut_v = {state, alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                    mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};

    int    n_vec = 0;
    int    n_err = 0;
    logic  chk_en = 1'b0;
    string tname = "reset";
    int    ncyc = 0;
    int    len_req_id = 0;
    int    len_done_id = 0;
    int    len_got = 0;
    int    len_exp = 0;

    // Single compare process: per-cycle output vector plus pending length checks
    always @(negedge clk) begin : cmp
        int dv;
        int de;
        dv = 0;
        de = 0;
        if (chk_en) begin
            dv = dv + 1;
            if (dut_v !== exp_v) begin
                de = de + 1;
                $display("FAIL %s t=%0t got=%h required=%h (state got %0d required %0d)",
                         tname, $time, dut_v, exp_v, dut_v.st, exp_v.st);
            end
        end
        if (len_req_id != len_done_id) begin
            dv = dv + 1;
            if (len_got != len_exp) begin
                de = de + 1;
                $display("FAIL %s_cycles got=%0d required=%0d", tname, len_got, len_exp);
            end
        end
        n_vec       <= n_vec + dv;
        n_err       <= n_err + de;
        len_done_id <= len_req_id;
    end

    // Outputs that a given state must show, straight from the state table
    function automatic outv_t outs(input logic [3:0] ph, input logic mr);
        outv_t o;
        o     = '0;
        o.st  = ph;
        o.aop = 3'b010;
        case (ph)
            4'd0:  begin o.mrd = 1'b1; o.sb = 2'b01; o.irw = mr; o.pc_en = mr; end
            4'd1:  begin
                o.sb  = 2'b11;
                o.ill = !(opcode inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02});
            end
            4'd2:  begin o.sa = 1'b1; o.sb = 2'b10; end
            4'd3:  begin o.iord = 1'b1; o.mrd = 1'b1; end
            4'd4:  begin o.m2r = 1'b1; o.rw = 1'b1; end
            4'd5:  begin o.iord = 1'b1; o.mwr = 1'b1; end
            4'd6:  begin
                o.sa = 1'b1;
                case (funct)
                    6'h20:   o.aop = 3'b010;
                    6'h22:   o.aop = 3'b110;
                    6'h24:   o.aop = 3'b000;
                    6'h25:   o.aop = 3'b001;
                    6'h2A:   o.aop = 3'b111;
                    default: o.ill = 1'b1;
                endcase
            end
            4'd7:  begin o.rdst = 1'b1; o.rw = 1'b1; end
            4'd8:  begin o.sa = 1'b1; o.aop = 3'b110; o.ps = 2'b01; o.pc_en = zero; end
            4'd9:  begin o.sa = 1'b1; o.sb = 2'b10; end
            4'd10: begin o.rw = 1'b1; end
            4'd11: begin o.ps = 2'b10; o.pc_en = 1'b1; end
            default: o.st = ph;
        endcase
        return o;
    endfunction

    // One clock cycle: drive inputs, publish expectation, advance
    task automatic cyc(input outv_t e, input logic mr, input logic r);
        rst       = r;
        mem_ready = mr;
        if (r) begin
            e.pc_en = 1'b0; e.irw = 1'b0; e.mwr = 1'b0;
            e.rw    = 1'b0; e.mrd = 1'b0; e.ill = 1'b0;
        end
        exp_v  = e;
        chk_en = 1'b1;
        ncyc   = ncyc + 1;
        @(posedge clk);
        #1;
    endtask

    // Memory-handshake state with w not-ready cycles offered first
    task automatic mem_phase(input logic [3:0] ph, input int w);
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        for (int i = 0; i < w; i++) cyc(outs(ph, 1'b0), 1'b0, 1'b0);
        cyc(outs(ph, 1'b1), 1'b1, 1'b0);
`else
        cyc(outs(ph, 1'b1), (w > 0) ? 1'b0 : 1'b1, 1'b0);
`endif
    endtask

    task automatic check_len(input int len_w, input int len_n);
        len_got = ncyc;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        len_exp = len_w;
`else
        len_exp = len_n;
`endif
        len_req_id = len_req_id + 1;
    endtask

    // Whole instruction from FETCH back to the next FETCH
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw,
                             input int len_w, input int len_n);
        tname  = nm;
        opcode = op;
        funct  = fn;
        zero   = z;
        ncyc   = 0;
        mem_phase(4'd0, fw);
        cyc(outs(4'd1, 1'b0), 1'b0, 1'b0);
        case (op)
            6'h23: begin
                cyc(outs(4'd2, 1'b0), 1'b0, 1'b0);
                mem_phase(4'd3, mw);
                cyc(outs(4'd4, 1'b0), 1'b0, 1'b0);
            end
            6'h2B: begin
                cyc(outs(4'd2, 1'b0), 1'b0, 1'b0);
                mem_phase(4'd5, mw);
            end
            6'h00: begin
                cyc(outs(4'd6, 1'b0), 1'b0, 1'b0);
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                    cyc(outs(4'd7, 1'b0), 1'b0, 1'b0);
                end
            end
            6'h04: cyc(outs(4'd8, 1'b0), 1'b0, 1'b0);
            6'h08: begin
                cyc(outs(4'd9, 1'b0), 1'b0, 1'b0);
                cyc(outs(4'd10, 1'b0), 1'b0, 1'b0);
            end
            6'h02: cyc(outs(4'd11, 1'b0), 1'b0, 1'b0);
            default: ncyc = ncyc + 0;
        endcase
        check_len(len_w, len_n);
    endtask

    initial begin
        // First edge under reset puts the FSM in FETCH; enables stay masked
        @(posedge clk);
        #1;
        tname  = "reset";
        opcode = 6'h00;
        funct  = 6'h20;
        cyc(outs(4'd0, 1'b1), 1'b1, 1'b1);

        //        name        op     funct  z     fw mw  wait nowait
        run_instr("add",      6'h00, 6'h20, 1'b0, 0, 0,  4,   4);
        run_instr("sub",      6'h00, 6'h22, 1'b1, 0, 0,  4,   4);
        run_instr("and",      6'h00, 6'h24, 1'b0, 0, 0,  4,   4);
        run_instr("or",       6'h00, 6'h25, 1'b0, 0, 0,  4,   4);
        run_instr("slt",      6'h00, 6'h2A, 1'b0, 0, 0,  4,   4);
        run_instr("add_fw2",  6'h00, 6'h20, 1'b0, 2, 0,  6,   4);
        run_instr("lw",       6'h23, 6'h00, 1'b0, 0, 0,  5,   5);
        run_instr("lw_mw2",   6'h23, 6'h00, 1'b0, 0, 2,  7,   5);
        run_instr("lw_fw1mw1",6'h23, 6'h11, 1'b1, 1, 1,  7,   5);
        run_instr("sw",       6'h2B, 6'h00, 1'b0, 0, 0,  4,   4);
        run_instr("sw_mw1",   6'h2B, 6'h00, 1'b0, 0, 1,  5,   4);
        run_instr("beq_z1",   6'h04, 6'h00, 1'b1, 0, 0,  3,   3);
        run_instr("beq_z0",   6'h04, 6'h00, 1'b0, 0, 0,  3,   3);
        run_instr("addi",     6'h08, 6'h00, 1'b0, 0, 0,  4,   4);
        run_instr("j",        6'h02, 6'h00, 1'b0, 0, 0,  3,   3);
        run_instr("j_fw1",    6'h02, 6'h00, 1'b1, 1, 0,  4,   3);
        run_instr("bad_op",   6'h3F, 6'h20, 1'b0, 0, 0,  2,   2);
        run_instr("bad_fn",   6'h00, 6'h00, 1'b0, 0, 0,  3,   3);

        // Reset while a store is in MEMWR: no write, FETCH on the next edge
        tname  = "rst_memwr";
        opcode = 6'h2B;
        funct  = 6'h00;
        zero   = 1'b0;
        mem_phase(4'd0, 0);
        cyc(outs(4'd1, 1'b0), 1'b0, 1'b0);
        cyc(outs(4'd2, 1'b0), 1'b0, 1'b0);
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        cyc(outs(4'd5, 1'b0), 1'b0, 1'b0);
`endif
        cyc(outs(4'd5, 1'b0), 1'b0, 1'b1);
        run_instr("after_rst_memwr", 6'h08, 6'h00, 1'b0, 0, 0, 4, 4);

        // Reset during a load's write-back cycle masks reg_write
        tname  = "rst_memwb";
        opcode = 6'h23;
        mem_phase(4'd0, 0);
        cyc(outs(4'd1, 1'b0), 1'b0, 1'b0);
        cyc(outs(4'd2, 1'b0), 1'b0, 1'b0);
        mem_phase(4'd3, 0);
        cyc(outs(4'd4, 1'b0), 1'b0, 1'b1);
        run_instr("after_rst_memwb", 6'h00, 6'h2A, 1'b0, 0, 0, 4, 4);

        tname  = "idle";
        opcode = 6'h00;
        funct  = 6'h20;
        cyc(outs(4'd0, 1'b1), 1'b1, 1'b0);
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
